// File: rtl/hps_pll_lock_sequencer.sv
// Purpose: sequences the capture PLL reset, qualifies its lock and gates the capture-domain reset.
// Latency: lock is seen SYNC_STAGES cycles late; outputs are registered alongside the state.
// Backpressure: none; lock/enable/restart are levels or pulses sampled every refclk cycle.
module hps_pll_lock_sequencer #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 50000,
    parameter int LOCK_STABLE     = 256,
    parameter int MAX_RETRIES     = 7,
    parameter int SYNC_STAGES     = 2,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          refclk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          restart,
    input  logic          pll_locked,
    output logic          pll_rst,
    output logic          capture_rst_n,
    output logic          ready,
    output logic          fail,
    output logic [RW-1:0] retry_count,
    output logic [7:0]    lock_loss_count
);

    localparam int TMAX_A = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int TMAX   = (TMAX_A > LOCK_STABLE) ? TMAX_A : LOCK_STABLE;
    localparam int TW     = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 locked_s;
    logic [TW-1:0]        timer;
    logic                 timer_clr;
    logic                 retry_clr;
    logic                 retry_inc;
    logic                 loss_inc;
    logic                 hold_done;
    logic                 lock_timeout;
    logic                 stable_done;
    logic                 retry_at_max;

    assign locked_s     = sync_q[SYNC_STAGES-1];
    assign hold_done    = (timer == TW'(RST_HOLD_CYCLES - 1));
    assign lock_timeout = (timer == TW'(LOCK_TIMEOUT - 1));
    assign stable_done  = (timer == TW'(LOCK_STABLE - 1));
    assign retry_at_max = (retry_count == RW'(MAX_RETRIES));

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        retry_clr = 1'b0;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else if (restart) begin
            // A restart is a fresh entry into RESET even if already there.
            state_nxt = ST_RESET;
            retry_clr = 1'b1;
            timer_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_RESET;
                end
                ST_RESET: begin
                    if (hold_done) begin
                        state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = ST_STABLE;
                    end else if (lock_timeout) begin
                        if (retry_at_max) begin
                            state_nxt = ST_FAIL;
                        end else begin
                            state_nxt = ST_RESET;
                            retry_inc = 1'b1;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (stable_done) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_nxt = ST_RESET;
                        loss_inc  = 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
        if (state_nxt != state) begin
            timer_clr = 1'b1;
        end
        // Retries belong to one bring-up attempt: a successful lock or a disable ends it.
        if ((state_nxt == ST_IDLE) || ((state_nxt == ST_RUN) && (state != ST_RUN))) begin
            retry_clr = 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturates so IDLE/FAIL dwell cannot wrap back onto a compare value.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else if (timer != {TW{1'b1}}) begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            retry_count <= '0;
        end else if (retry_clr) begin
            retry_count <= '0;
        end else if (retry_inc) begin
            retry_count <= retry_count + RW'(1);
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_count <= 8'd0;
        end else if (loss_inc && (lock_loss_count != 8'hFF)) begin
            lock_loss_count <= lock_loss_count + 8'd1;
        end
    end

    // Output flops decode the state being entered so they change on the same edge.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst       <= 1'b1;
            capture_rst_n <= 1'b0;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            pll_rst       <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET) ||
                             (state_nxt == ST_FAIL);
            capture_rst_n <= (state_nxt == ST_RUN);
            ready         <= (state_nxt == ST_RUN);
            fail          <= (state_nxt == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_hps_pll_lock_sequencer.sv
// Bench for hps_pll_lock_sequencer: deadline-based reference model feeds an expected-output
// queue each cycle; a monitor pops and compares; directed scenarios add targeted checks.
module tb_hps_pll_lock_sequencer;

    localparam int RH = 16;
    localparam int LT = 100;
    localparam int LS = 32;
    localparam int MR = 3;
    localparam int SS = 2;
    localparam int RW = 2;

    logic          refclk = 1'b0;
    logic          rst_n  = 1'b1;
    logic          enable = 1'b0;
    logic          restart = 1'b0;
    logic          pll_locked = 1'b0;
    logic          pll_rst;
    logic          capture_rst_n;
    logic          ready;
    logic          fail;
    logic [RW-1:0] retry_count;
    logic [7:0]    lock_loss_count;

    int n_chk  = 0;
    int n_fail = 0;

    hps_pll_lock_sequencer #(
        .RST_HOLD_CYCLES(RH),
        .LOCK_TIMEOUT   (LT),
        .LOCK_STABLE    (LS),
        .MAX_RETRIES    (MR),
        .SYNC_STAGES    (SS)
    ) dut (
        .refclk         (refclk),
        .rst_n          (rst_n),
        .enable         (enable),
        .restart        (restart),
        .pll_locked     (pll_locked),
        .pll_rst        (pll_rst),
        .capture_rst_n  (capture_rst_n),
        .ready          (ready),
        .fail           (fail),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #10 refclk = ~refclk;

    // Reference model: phases with absolute entry times; "age" is edges since entry.
    localparam int M_IDLE = 0, M_RESET = 1, M_WAIT = 2, M_STAB = 3, M_RUN = 4, M_FAIL = 5;
    int          cyc, entered, age, m_ph, nph, m_retry, m_loss;
    bit          ls, fresh, m_pr;
    bit          hist[$];
    logic [13:0] exp_q[$];

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = M_IDLE; m_retry = 0; m_loss = 0; cyc = 0; entered = 0;
            hist.delete();
            for (int i = 0; i < SS; i++) hist.push_back(1'b0);
            exp_q.delete();
        end else begin
            ls = hist.pop_front();
            hist.push_back(pll_locked);
            cyc++;
            age = cyc - entered;
            nph = m_ph;
            fresh = 1'b0;
            if (!enable) begin
                nph = M_IDLE;
            end else if (restart) begin
                nph = M_RESET; m_retry = 0; fresh = 1'b1;
            end else begin
                case (m_ph)
                    M_IDLE:  nph = M_RESET;
                    M_RESET: if (age == RH) nph = M_WAIT;
                    M_WAIT: begin
                        if (ls) nph = M_STAB;
                        else if (age == LT) begin
                            if (m_retry == MR) nph = M_FAIL;
                            else begin m_retry++; nph = M_RESET; end
                        end
                    end
                    M_STAB: begin
                        if (!ls) nph = M_WAIT;
                        else if (age == LS) nph = M_RUN;
                    end
                    M_RUN: begin
                        if (!ls) begin
                            nph = M_RESET;
                            if (m_loss < 255) m_loss++;
                        end
                    end
                    default: ;
                endcase
            end
            if (nph != m_ph || fresh) entered = cyc;
            if (nph == M_IDLE || (nph == M_RUN && m_ph != M_RUN)) m_retry = 0;
            m_ph = nph;
            m_pr = (m_ph == M_IDLE) || (m_ph == M_RESET) || (m_ph == M_FAIL);
            exp_q.push_back({m_pr, m_ph == M_RUN, m_ph == M_RUN, m_ph == M_FAIL,
                             2'(m_retry), 8'(m_loss)});
        end
    end

    logic [13:0] exp_v, act_v;
    always @(negedge refclk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {pll_rst, capture_rst_n, ready, fail, retry_count, lock_loss_count};
            n_chk++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL outputs t=%0t actual=%b required=%b (rst,cap,rdy,fail,retry,loss)",
                         $time, act_v, exp_v);
            end
        end
    end

    // pll_rst high-pulse widths, measured in cycles.
    int hi_run = 0;
    int falls  = 0;
    int widths[$];
    always @(negedge refclk) begin
        if (pll_rst) hi_run++;
        else if (hi_run > 0) begin
            widths.push_back(hi_run);
            falls++;
            hi_run = 0;
        end
    end

    task automatic check(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return ready;
            2:       return fail;
            default: return capture_rst_n;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input int budget,
                            input string nm, output int n);
        n = 0;
        while (sig(sel) !== val && n < budget) begin
            @(negedge refclk);
            n++;
        end
        if (sig(sel) !== val) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout after %0d cycles", nm, n);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, g;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge refclk);
        rst_n = 1'b1;
        @(negedge refclk);
        check("reset_pll_rst", pll_rst, 1);
        check("reset_ready", ready, 0);

        // Normal bring-up
        enable = 1'b1;
        wait_for(0, 1'b0, 100, "bringup_rst_fall", n);
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        wait_for(1, 1'b1, 400, "bringup_ready", n);
        check_range("bringup_ready_delay", n, LS, LS + 4);
        check("bringup_retry", retry_count, 0);
        check("bringup_cap_rst_n", capture_rst_n, 1);

        // Fresh sequence, then a lock glitch inside the stable window
        pll_locked = 1'b0;
        restart = 1'b1;
        @(negedge refclk);
        restart = 1'b0;
        wait_for(0, 1'b0, 100, "glitch_rst_fall", n);
        repeat (4) @(negedge refclk);
        pll_locked = 1'b1;
        g = $urandom_range(4, LS - 8);
        repeat (g) @(negedge refclk);
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        check("glitch_ready_low", ready, 0);
        pll_locked = 1'b1;
        wait_for(1, 1'b1, 400, "glitch_ready", n);
        check_range("glitch_full_window", n, LS, LS + 4);

        // Lock loss in RUN
        repeat ($urandom_range(1, 8)) @(negedge refclk);
        pll_locked = 1'b0;
        wait_for(1, 1'b0, 10, "loss_ready_drop", n);
        check_range("loss_drop_latency", n, 1, SS + 1);
        check("loss_cap_rst_n", capture_rst_n, 0);
        wait_for(0, 1'b0, 40, "loss_rst_fall", n);
        @(negedge refclk);
        check("loss_pulse_width", widths[widths.size() - 1], RH);
        check("loss_count_1", lock_loss_count, 1);
        pll_locked = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wait_for(1, 1'b1, 200, "loop_ready", n);
            repeat ($urandom_range(0, 5)) @(negedge refclk);
            pll_locked = 1'b0;
            wait_for(0, 1'b1, 10, "loop_rst_rise", n);
            wait_for(0, 1'b0, 40, "loop_rst_fall", n);
            repeat ($urandom_range(1, 15)) @(negedge refclk);
            pll_locked = 1'b1;
        end
        wait_for(1, 1'b1, 200, "loop_final_ready", n);
        check("loss_count_sat", lock_loss_count, 255);

        // Asynchronous reset between edges while in RUN
        @(posedge refclk);
        #5 rst_n = 1'b0;
        #1;
        check("areset_pll_rst", pll_rst, 1);
        check("areset_cap_rst_n", capture_rst_n, 0);
        check("areset_ready", ready, 0);
        check("areset_fail", fail, 0);
        check("areset_loss", lock_loss_count, 0);
        pll_locked = 1'b0;
        @(negedge refclk);
        rst_n = 1'b1;

        // Never lock: retries then FAIL
        base = falls;
        wait_for(2, 1'b1, 2000, "nolock_fail", n);
        check("nolock_fail", fail, 1);
        check("nolock_retry", retry_count, MR);
        @(negedge refclk);
        check("nolock_pulses", falls - base, MR + 1);
        for (int k = 1; k <= MR; k++)
            check("nolock_width", widths[widths.size() - k], RH);
        repeat (5) @(negedge refclk);
        check("nolock_rst_held", pll_rst, 1);

        // restart out of FAIL
        restart = 1'b1;
        @(negedge refclk);
        restart = 1'b0;
        check("restart_fail_clr", fail, 0);
        check("restart_retry_clr", retry_count, 0);
        check("restart_pll_rst", pll_rst, 1);

        // enable=0 in WAIT_LOCK
        wait_for(0, 1'b0, 40, "dis_rst_fall", n);
        repeat (3) @(negedge refclk);
        enable = 1'b0;
        @(negedge refclk);
        check("disable_pll_rst", pll_rst, 1);

        // restart together with enable=0 stays in IDLE
        enable = 1'b1;
        wait_for(0, 1'b0, 40, "both_rst_fall", n);
        repeat (2) @(negedge refclk);
        restart = 1'b1;
        enable = 1'b0;
        @(negedge refclk);
        restart = 1'b0;
        repeat (RH + 4) @(negedge refclk);
        check("both_idle_pll_rst", pll_rst, 1);

        // Randomized soak against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge refclk);
            enable  = ($urandom_range(0, 99) < 97);
            restart = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 59) == 0) pll_locked = ~pll_locked;
        end
        restart = 1'b0;
        repeat (4) @(negedge refclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
